// File: rtl/counter_seq_checker_pkg.sv
// Shared types and the counter reference model for the step counter bus.
package counter_seq_checker_pkg;

    localparam int unsigned DEF_N    = 32;
    localparam int unsigned DEF_STEP = 2;
    localparam int unsigned MAX_N    = 64;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    // Next value of an n-bit counter (n <= MAX_N): all-ones wraps to zero,
    // otherwise add step modulo 2^n.
    function automatic logic [MAX_N-1:0] count_next(input logic [MAX_N-1:0] x,
                                                    input int unsigned      n,
                                                    input int unsigned      step);
        logic [MAX_N-1:0] mask;
        mask = (n >= MAX_N) ? '1 : ((MAX_N'(1) << n) - MAX_N'(1));
        if ((x & mask) == mask) begin
            return '0;
        end
        return (x + MAX_N'(step)) & mask;
    endfunction

endpackage

// File: rtl/counter_step_model.sv
// Combinational prediction of the counter's next value.
//   prev_count : previously observed count
//   prev_enb   : enable seen with prev_count
//   exp_c      : value the counter must show next
module counter_step_model
    import counter_seq_checker_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned STEP = DEF_STEP
) (
    input  logic [N-1:0] prev_count,
    input  logic         prev_enb,
    output logic [N-1:0] exp_c
);

    always_comb begin
        exp_c = prev_count;
        if (prev_enb) begin
            exp_c = N'(count_next(MAX_N'(prev_count), N, STEP));
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side monitor for an enabled step counter: locks onto a consistent
// sequence and counts deviations seen while locked.
//   clk, reset : clock, synchronous active-high reset
//   count_enb  : enable seen by the observed counter
//   count      : observed counter value
//   clr_err    : synchronous clear of err_cnt (wins over an increment)
//   locked     : sequence tracked for LOCK_CNT consecutive transitions
//   err_pulse  : one-cycle pulse per mismatch while locked
//   err_cnt    : saturating count of locked-state mismatches
//   expected   : prediction for the current cycle's count
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned STEP     = DEF_STEP,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_enb,
    input  logic [N-1:0]     count,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [N-1:0]     expected
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_e           state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_d;
    logic [N-1:0]     prev_count;
    logic             prev_enb;
    logic [N-1:0]     exp_c;
    logic [N-1:0]     exp_next_c;
    logic             locked_d, err_pulse_d;
    logic [ERR_W-1:0] err_cnt_d;
    logic             match_c;

    // Prediction for this cycle's sample, from the previous sample.
    counter_step_model #(.N(N), .STEP(STEP)) u_pred_now (
        .prev_count (prev_count),
        .prev_enb   (prev_enb),
        .exp_c      (exp_c)
    );

    // Prediction for next cycle's sample, registered into expected so the
    // output lines up with the sample it predicts.
    counter_step_model #(.N(N), .STEP(STEP)) u_pred_next (
        .prev_count (count),
        .prev_enb   (count_enb),
        .exp_c      (exp_next_c)
    );

    assign match_c = (count == exp_c);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        good_d      = good_cnt_q;
        locked_d    = locked;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt;
        case (state_q)
            ST_ACQUIRE: begin
                state_d = ST_TRACK;
                good_d  = '0;
            end
            ST_TRACK: begin
                if (match_c) begin
                    if (good_cnt_q >= GW'(LOCK_CNT - 1)) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                        good_d   = GW'(LOCK_CNT);
                    end else begin
                        good_d = good_cnt_q + GW'(1);
                    end
                end else begin
                    good_d = '0;
                end
            end
            ST_LOCKED: begin
                if (!match_c) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt_d = err_cnt + ERR_W'(1);
                    end
                    locked_d = 1'b0;
                    state_d  = ST_TRACK;
                    good_d   = '0;
                end
            end
            default: begin
                state_d  = ST_ACQUIRE;
                good_d   = '0;
                locked_d = 1'b0;
            end
        endcase
        if (clr_err) begin
            err_cnt_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACQUIRE;
            good_cnt_q <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            expected   <= '0;
            prev_count <= '0;
            prev_enb   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_d;
            locked     <= locked_d;
            err_pulse  <= err_pulse_d;
            err_cnt    <= err_cnt_d;
            expected   <= exp_next_c;
            prev_count <= count;
            prev_enb   <= count_enb;
        end
    end

endmodule
